// File: rtl/kernel_cra_pkg.sv
// Shared types and default CRA constants for the kernel launch sequencer.
// No logic: state encoding, table entry layout, start/clear command words.
package kernel_cra_pkg;

    localparam int CRA_ADDR_W = 8;
    localparam int CRA_DATA_W = 64;
    localparam int CRA_BE_W   = CRA_DATA_W / 8;

    localparam logic [CRA_ADDR_W-1:0] DEF_STATUS_ADDR = 8'h00;
    localparam logic [CRA_DATA_W-1:0] DEF_START_DATA  = 64'h1;
    localparam logic [CRA_BE_W-1:0]   DEF_START_BE    = 8'h0F;
    localparam logic [CRA_DATA_W-1:0] DEF_CLEAR_DATA  = 64'h0;
    localparam logic [CRA_BE_W-1:0]   DEF_CLEAR_BE    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_LAUNCH,
        ST_WAIT_IRQ,
        ST_RD_STATUS,
        ST_WAIT_RD,
        ST_CLEAR,
        ST_FIN
    } launcher_state_t;

    typedef struct packed {
        logic [CRA_ADDR_W-1:0] addr;
        logic [CRA_DATA_W-1:0] data;
        logic [CRA_BE_W-1:0]   be;
    } cra_arg_t;

    localparam int CRA_ARG_W = $bits(cra_arg_t);

endpackage

// File: rtl/kernel_arg_table.sv
// Argument table: one synchronous write port, one registered read port (1-cycle latency).
// No backpressure; rd_dat holds its value while rd_en is low.
module kernel_arg_table
    import kernel_cra_pkg::*;
#(
    parameter int ARG_DEPTH = 32
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         wr_en,
    input  logic [$clog2(ARG_DEPTH)-1:0] wr_idx,
    input  logic [CRA_ARG_W-1:0]         wr_dat,
    input  logic                         rd_en,
    input  logic [$clog2(ARG_DEPTH)-1:0] rd_idx,
    output logic [CRA_ARG_W-1:0]         rd_dat
);

    logic [CRA_ARG_W-1:0] mem_q [ARG_DEPTH];
    logic [CRA_ARG_W-1:0] rd_dat_q;
    logic [CRA_ARG_W-1:0] rd_dat_d;

    // Storage is deliberately not reset; contents are undefined until loaded.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/kernel_cra_launcher.sv
// Replays the argument table onto the kernel CRA slave, writes start, waits IRQ/timeout, reads and clears status.
// First CRA write 2 cycles after start, args back-to-back; commands hold under cra_waitrequest, one outstanding.
module kernel_cra_launcher
    import kernel_cra_pkg::*;
#(
    parameter int                  ADDR_W      = 8,
    parameter int                  DATA_W      = 64,
    parameter int                  ARG_DEPTH   = 32,
    parameter logic [ADDR_W-1:0]   STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [DATA_W-1:0]   START_DATA  = DEF_START_DATA,
    parameter logic [DATA_W-1:0]   CLEAR_DATA  = DEF_CLEAR_DATA,
    parameter int                  TIMEOUT_CYC = 0
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         arg_wr_en,
    input  logic [$clog2(ARG_DEPTH)-1:0] arg_wr_idx,
    input  logic [ADDR_W-1:0]            arg_wr_addr,
    input  logic [DATA_W-1:0]            arg_wr_data,
    input  logic [DATA_W/8-1:0]          arg_wr_be,
    input  logic [$clog2(ARG_DEPTH):0]   arg_count,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout,
    output logic [DATA_W-1:0]            status_word,
    output logic [ADDR_W-1:0]            cra_address,
    output logic                         cra_write,
    output logic                         cra_read,
    output logic [DATA_W-1:0]            cra_writedata,
    output logic [DATA_W/8-1:0]          cra_byteenable,
    input  logic                         cra_waitrequest,
    input  logic [DATA_W-1:0]            cra_readdata,
    input  logic                         cra_readdatavalid,
    input  logic                         kernel_irq
);

    localparam int IDX_W = $clog2(ARG_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    launcher_state_t state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] status_q, status_d;
    logic              cra_write_q, cra_write_d;
    logic              cra_read_q, cra_read_d;
    logic [ADDR_W-1:0] cra_addr_q, cra_addr_d;
    logic [DATA_W-1:0] cra_data_q, cra_data_d;
    logic [BE_W-1:0]   cra_be_q, cra_be_d;

    cra_arg_t          tbl_wr_arg;
    cra_arg_t          tbl_rd_arg;
    logic              tbl_wr_en;
    logic              tbl_rd_en;
    logic [IDX_W-1:0]  tbl_rd_idx;
    logic              slot_free;

    assign tbl_wr_en  = arg_wr_en && (state_q == ST_IDLE);
    assign tbl_wr_arg = '{addr: arg_wr_addr, data: arg_wr_data, be: arg_wr_be};

    kernel_arg_table #(
        .ARG_DEPTH (ARG_DEPTH)
    ) u_arg_table (
        .clock  (clock),
        .resetn (resetn),
        .wr_en  (tbl_wr_en),
        .wr_idx (arg_wr_idx),
        .wr_dat (tbl_wr_arg),
        .rd_en  (tbl_rd_en),
        .rd_idx (tbl_rd_idx),
        .rd_dat (tbl_rd_arg)
    );

    // The command slot can take a new command when idle or when the current one completes now.
    assign slot_free = !(cra_write_q || cra_read_q) || !cra_waitrequest;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        load_cnt_d  = load_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = timeout_q;
        status_d    = status_q;
        cra_write_d = cra_write_q;
        cra_read_d  = cra_read_q;
        cra_addr_d  = cra_addr_q;
        cra_data_d  = cra_data_q;
        cra_be_d    = cra_be_q;
        tbl_rd_en   = 1'b0;
        tbl_rd_idx  = IDX_W'(load_cnt_q + CNT_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d    = arg_count;
                    load_cnt_d = '0;
                    timeout_d  = 1'b0;
                    tbl_rd_en  = 1'b1;
                    tbl_rd_idx = '0;
                    state_d    = ST_ARGS;
                end
            end
            ST_ARGS: begin
                // Entry load_cnt_q is already in the table read register; prefetch the next one.
                if (slot_free) begin
                    cra_write_d = 1'b1;
                    if (load_cnt_q != count_q) begin
                        cra_addr_d = tbl_rd_arg.addr;
                        cra_data_d = tbl_rd_arg.data;
                        cra_be_d   = tbl_rd_arg.be;
                        load_cnt_d = load_cnt_q + CNT_W'(1);
                        tbl_rd_en  = 1'b1;
                    end else begin
                        cra_addr_d = STATUS_ADDR;
                        cra_data_d = START_DATA;
                        cra_be_d   = DEF_START_BE;
                        state_d    = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                if (!cra_waitrequest) begin
                    cra_write_d = 1'b0;
                    tmo_cnt_d   = '0;
                    state_d     = ST_WAIT_IRQ;
                end
            end
            ST_WAIT_IRQ: begin
                if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
                if (kernel_irq) begin
                    cra_read_d = 1'b1;
                    cra_addr_d = STATUS_ADDR;
                    state_d    = ST_RD_STATUS;
                end else if ((TIMEOUT_CYC != 0) && (tmo_cnt_q == TMO_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FIN;
                end
            end
            ST_RD_STATUS: begin
                if (!cra_waitrequest) begin
                    cra_read_d = 1'b0;
                    state_d    = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (cra_readdatavalid) begin
                    status_d    = cra_readdata;
                    cra_write_d = 1'b1;
                    cra_addr_d  = STATUS_ADDR;
                    cra_data_d  = CLEAR_DATA;
                    cra_be_d    = DEF_CLEAR_BE;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!cra_waitrequest) begin
                    cra_write_d = 1'b0;
                    state_d     = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            load_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            status_q    <= '0;
            cra_write_q <= 1'b0;
            cra_read_q  <= 1'b0;
            cra_addr_q  <= '0;
            cra_data_q  <= '0;
            cra_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            load_cnt_q  <= load_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
            status_q    <= status_d;
            cra_write_q <= cra_write_d;
            cra_read_q  <= cra_read_d;
            cra_addr_q  <= cra_addr_d;
            cra_data_q  <= cra_data_d;
            cra_be_q    <= cra_be_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign timeout        = timeout_q;
    assign status_word    = status_q;
    assign cra_address    = cra_addr_q;
    assign cra_write      = cra_write_q;
    assign cra_read       = cra_read_q;
    assign cra_writedata  = cra_data_q;
    assign cra_byteenable = cra_be_q;

endmodule

// File: tb/tb_kernel_cra_launcher.sv
// Directed bench for kernel_cra_launcher: CRA slave model with waitrequest/readback, write log, timed checks.
module tb_kernel_cra_launcher;

    localparam int ARG_DEPTH = 32;
    localparam int TMO       = 50;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        arg_wr_en = 1'b0;
    logic [4:0]  arg_wr_idx = '0;
    logic [7:0]  arg_wr_addr = '0;
    logic [63:0] arg_wr_data = '0;
    logic [7:0]  arg_wr_be = '0;
    logic [5:0]  arg_count = '0;
    logic        start = 1'b0;
    logic        busy, done, timeout;
    logic [63:0] status_word;
    logic [7:0]  cra_address;
    logic        cra_write, cra_read;
    logic [63:0] cra_writedata;
    logic [7:0]  cra_byteenable;
    logic        cra_waitrequest = 1'b0;
    logic [63:0] cra_readdata = '0;
    logic        cra_readdatavalid = 1'b0;
    logic        kernel_irq = 1'b0;

    kernel_cra_launcher #(
        .ARG_DEPTH   (ARG_DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clock             (clock),
        .resetn            (resetn),
        .arg_wr_en         (arg_wr_en),
        .arg_wr_idx        (arg_wr_idx),
        .arg_wr_addr       (arg_wr_addr),
        .arg_wr_data       (arg_wr_data),
        .arg_wr_be         (arg_wr_be),
        .arg_count         (arg_count),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .timeout           (timeout),
        .status_word       (status_word),
        .cra_address       (cra_address),
        .cra_write         (cra_write),
        .cra_read          (cra_read),
        .cra_writedata     (cra_writedata),
        .cra_byteenable    (cra_byteenable),
        .cra_waitrequest   (cra_waitrequest),
        .cra_readdata      (cra_readdata),
        .cra_readdatavalid (cra_readdatavalid),
        .kernel_irq        (kernel_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
        logic [7:0]  be;
        int          cyc;
    } wr_rec_t;

    wr_rec_t     wr_log[$];
    int          rd_cnt = 0;
    logic [7:0]  rd_addr = '0;
    int          cyc = 0;
    int          proto_err = 0;
    logic        held = 1'b0;
    logic [81:0] held_cmd = '0;
    logic [63:0] rsp_val = '0;
    int          checks = 0;
    int          errors = 0;

    // Bus monitor: logs completed transfers and flags commands that change under waitrequest.
    always @(posedge clock) begin
        if (!resetn) begin
            held = 1'b0;
        end else begin
            if (held && ({cra_write, cra_read, cra_address, cra_writedata, cra_byteenable} !== held_cmd))
                proto_err++;
            if (cra_write && cra_read)
                proto_err++;
            if (cra_write && !cra_waitrequest)
                wr_log.push_back('{cra_address, cra_writedata, cra_byteenable, cyc});
            if (cra_read && !cra_waitrequest) begin
                rd_cnt++;
                rd_addr = cra_address;
            end
            held     = (cra_write || cra_read) && cra_waitrequest;
            held_cmd = {cra_write, cra_read, cra_address, cra_writedata, cra_byteenable};
        end
        cyc++;
    end

    // Read responder: one-cycle readdatavalid the cycle after an accepted read.
    always @(posedge clock) begin
        if (resetn && cra_read && !cra_waitrequest) begin
            #1;
            cra_readdata      = rsp_val;
            cra_readdatavalid = 1'b1;
            @(posedge clock);
            #1;
            cra_readdatavalid = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [7:0] a,
                          input logic [63:0] d, input logic [7:0] b);
        logic [79:0] obs;
        obs = '1;
        if (i < wr_log.size())
            obs = {wr_log[i].addr, wr_log[i].data, wr_log[i].be};
        chk(tag, obs, {a, d, b});
    endtask

    function automatic int wr_cyc(input int i);
        return (i < wr_log.size()) ? wr_log[i].cyc : -1;
    endfunction

    task automatic load(input int idx, input logic [7:0] a, input logic [63:0] d, input logic [7:0] b);
        arg_wr_en   = 1'b1;
        arg_wr_idx  = 5'(idx);
        arg_wr_addr = a;
        arg_wr_data = d;
        arg_wr_be   = b;
        tick();
        arg_wr_en   = 1'b0;
    endtask

    task automatic load_std();
        load(0, 8'h05, 64'h1_0000_0000, 8'hF0);
        load(1, 8'h06, 64'h1,           8'h0F);
        load(2, 8'h0D, 64'h1000,        8'h0F);
    endtask

    task automatic pulse_start(input int n, output int s);
        arg_count = 6'(n);
        start     = 1'b1;
        s         = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int d);
        d = -1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                d = cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int s;
        int d;

        tick(2);
        chk("rst_ctrl", {busy, done, timeout, cra_write, cra_read, cra_address, cra_byteenable}, '0);
        chk("rst_wdata", cra_writedata, '0);
        chk("rst_status", status_word, '0);
        resetn = 1'b1;
        tick();
        load_std();

        // Back-to-back replay, then IRQ 20 cycles after start with readback 0xA.
        wr_log.delete();
        rd_cnt = 0;
        pulse_start(3, s);
        chk("t1_busy_rise", busy, 1'b1);
        tick(19);
        kernel_irq = 1'b1;
        rsp_val    = 64'hA;
        wait_done(100, d);
        chk("t1_done_cyc", d, s + 24);
        chk("t1_wr_cnt", wr_log.size(), 5);
        chk_wr("t1_wr0", 0, 8'h05, 64'h1_0000_0000, 8'hF0);
        chk_wr("t1_wr1", 1, 8'h06, 64'h1, 8'h0F);
        chk_wr("t1_wr2", 2, 8'h0D, 64'h1000, 8'h0F);
        chk_wr("t1_start", 3, 8'h00, 64'h1, 8'h0F);
        chk_wr("t1_clear", 4, 8'h00, 64'h0, 8'hFF);
        chk("t1_cycs", {wr_cyc(0), wr_cyc(1), wr_cyc(2), wr_cyc(3)}, {s + 2, s + 3, s + 4, s + 5});
        chk("t1_rd", {rd_cnt, 24'd0, rd_addr}, {32'd1, 24'd0, 8'h00});
        chk("t1_status", status_word, 64'hA);
        chk("t1_timeout", timeout, 1'b0);
        kernel_irq = 1'b0;
        tick();
        chk("t1_after_done", {done, busy}, 2'b00);

        // Waitrequest held for 3 cycles on the second write; IRQ already high on WAIT_IRQ entry.
        wr_log.delete();
        rd_cnt = 0;
        pulse_start(3, s);
        tick(2);
        cra_waitrequest = 1'b1;
        chk("t2_hold_a", {cra_write, cra_address}, {1'b1, 8'h06});
        tick(2);
        chk("t2_hold_b", {cra_write, cra_read, cra_address, cra_writedata, cra_byteenable},
            {1'b1, 1'b0, 8'h06, 64'h1, 8'h0F});
        tick();
        cra_waitrequest = 1'b0;
        kernel_irq      = 1'b1;
        rsp_val         = 64'h5;
        wait_done(100, d);
        chk("t2_done_cyc", d, s + 13);
        chk("t2_wr_cnt", wr_log.size(), 5);
        chk_wr("t2_wr1", 1, 8'h06, 64'h1, 8'h0F);
        chk_wr("t2_wr2", 2, 8'h0D, 64'h1000, 8'h0F);
        chk("t2_cycs", {wr_cyc(0), wr_cyc(1), wr_cyc(2), wr_cyc(3)}, {s + 2, s + 6, s + 7, s + 8});
        chk("t2_status", status_word, 64'h5);
        kernel_irq = 1'b0;
        tick();

        // Timeout: IRQ never raised.
        wr_log.delete();
        rd_cnt = 0;
        pulse_start(0, s);
        wait_done(200, d);
        chk("t4_done_cyc", d, s + 53);
        chk("t4_timeout", timeout, 1'b1);
        chk("t4_no_read", rd_cnt, 0);
        chk("t4_wr_cnt", wr_log.size(), 1);
        chk_wr("t4_start", 0, 8'h00, 64'h1, 8'h0F);
        tick(3);
        chk("t4_sticky", {timeout, busy}, 2'b10);
        chk("t4_status_kept", status_word, 64'h5);
        pulse_start(0, s);
        chk("t4_clear_on_start", timeout, 1'b0);
        kernel_irq = 1'b1;
        rsp_val    = 64'h3;
        wait_done(100, d);
        chk("t4b_done_seen", d >= 0, 1'b1);
        kernel_irq = 1'b0;
        tick();

        // arg_count=0 with start and a table write issued while busy.
        wr_log.delete();
        rd_cnt = 0;
        pulse_start(0, s);
        start       = 1'b1;
        arg_wr_en   = 1'b1;
        arg_wr_idx  = 5'd0;
        arg_wr_addr = 8'hAA;
        arg_wr_data = 64'hDEAD_BEEF;
        arg_wr_be   = 8'h33;
        tick();
        start     = 1'b0;
        arg_wr_en = 1'b0;
        tick(2);
        kernel_irq = 1'b1;
        rsp_val    = 64'h7;
        wait_done(100, d);
        chk("t5_done_cyc", d, s + 8);
        kernel_irq = 1'b0;
        tick(5);
        chk("t5_no_relaunch", busy, 1'b0);
        chk("t5_wr_cnt", wr_log.size(), 2);
        chk_wr("t5_start_only", 0, 8'h00, 64'h1, 8'h0F);
        wr_log.delete();
        pulse_start(1, s);
        kernel_irq = 1'b1;
        wait_done(100, d);
        chk_wr("t5_table_kept", 0, 8'h05, 64'h1_0000_0000, 8'hF0);
        kernel_irq = 1'b0;
        tick();

        // Asynchronous reset while a write is stalled.
        cra_waitrequest = 1'b1;
        pulse_start(3, s);
        tick();
        chk("t6_stalled", {cra_write, cra_address}, {1'b1, 8'h05});
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_ctrl", {busy, done, timeout, cra_write, cra_read, cra_address, cra_byteenable}, '0);
        chk("t6_rst_data", {cra_writedata, status_word}, '0);
        tick(2);
        resetn          = 1'b1;
        cra_waitrequest = 1'b0;
        tick();
        load_std();
        wr_log.delete();
        pulse_start(3, s);
        kernel_irq = 1'b1;
        rsp_val    = 64'h9;
        wait_done(100, d);
        chk("t6_done_cyc", d, s + 10);
        chk("t6_wr_cnt", wr_log.size(), 5);
        chk_wr("t6_wr2", 2, 8'h0D, 64'h1000, 8'h0F);
        chk("t6_cycs", {wr_cyc(0), wr_cyc(1), wr_cyc(2), wr_cyc(3)}, {s + 2, s + 3, s + 4, s + 5});
        chk("t6_status", status_word, 64'h9);
        kernel_irq = 1'b0;
        tick(2);

        chk("protocol", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_cra_launcher.md
# kernel_cra_launcher

Synthesizable launch sequencer driving a kernel system's CRA (control/register access) Avalon-MM slave, the same port the simulation top currently drives by hand with `write_word` calls. It holds a table of kernel argument writes (address, 64-bit data, byteenable), loaded beforehand by a host-side port. On `start` it replays the table onto CRA and writes the start word. It then waits for `kernel_irq` (or a timeout), reads the status register, clears it, and reports completion. It sits between host control logic and the kernel system's CRA slave.

## Interface
- `ADDR_W`, 8, CRA word address width
- `DATA_W`, 64, CRA data width; byteenable width is `DATA_W/8`
- `ARG_DEPTH`, 32, argument table entries (power of two)
- `STATUS_ADDR`, 8'h0, CRA address of the start/status register
- `START_DATA`, 64'h1, start word, written with byteenable 8'h0F
- `CLEAR_DATA`, 64'h0, status clear word, written with byteenable 8'hFF
- `TIMEOUT_CYC`, 0, IRQ wait limit in cycles; 0 disables the timeout

Ports:
- `clock`  in  1  single clock
- `resetn`  in  1  asynchronous, active-low reset
- `arg_wr_en`  in  1  load one table entry
- `arg_wr_idx`  in  $clog2(ARG_DEPTH)  entry index
- `arg_wr_addr` / `arg_wr_data` / `arg_wr_be`  in  ADDR_W / DATA_W / DATA_W/8  entry contents
- `arg_count`  in  $clog2(ARG_DEPTH)+1  entries to replay; 0 is legal
- `start`  in  1  launch pulse
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle completion pulse
- `timeout`  out  1  sticky; set when the IRQ wait expired, cleared on next `start`
- `status_word`  out  DATA_W  last status readback
- `cra_address`, `cra_write`, `cra_read`, `cra_writedata`, `cra_byteenable`  out  CRA master
- `cra_waitrequest`, `cra_readdata`, `cra_readdatavalid`  in  CRA master
- `kernel_irq`  in  1  kernel completion interrupt, level

## Operation
- The table is a synchronous-write, registered-read memory.
  - Writes via `arg_wr_*` are accepted only while `busy`=0. They are ignored while busy.
- `start` is accepted only in IDLE. `arg_count` is sampled at that cycle.
- FSM states: IDLE → ARGS → LAUNCH → WAIT_IRQ → RD_STATUS → WAIT_RD → CLEAR → FIN → IDLE.
  - ARGS: issue entries 0..arg_count-1 in order. If arg_count=0, go straight to LAUNCH.
  - LAUNCH: write `START_DATA` to `STATUS_ADDR`.
  - WAIT_IRQ: exit when `kernel_irq`=1, or when the timeout counter reaches `TIMEOUT_CYC`. On timeout set `timeout` and go to FIN, skipping the read and clear.
  - RD_STATUS: assert `cra_read` at `STATUS_ADDR`.
  - WAIT_RD: capture `cra_readdata` into `status_word` on `cra_readdatavalid`.
  - CLEAR: write `CLEAR_DATA` to `STATUS_ADDR`.
  - FIN: `done`=1 for one cycle.
- Avalon rules:
  - command signals hold stable while `cra_waitrequest`=1;
  - a transfer completes on a cycle with the command asserted and `cra_waitrequest`=0;
  - at most one command is outstanding;
  - `cra_read` and `cra_write` are never asserted together.
- `kernel_irq` already high on entry to WAIT_IRQ exits in one cycle. An IRQ during ARGS/LAUNCH is not latched; only the level is checked in WAIT_IRQ.
- `start` while busy is ignored.

## Timing
- Reset values:
  - `busy`, `done`, `timeout`, `cra_write`, `cra_read` = 0;
  - `status_word`, `cra_address`, `cra_writedata`, `cra_byteenable` = 0;
  - FSM = IDLE; table contents are undefined.
- `start` at cycle 0 → first `cra_write` at cycle 2, allowing one cycle for the table read.
- With `cra_waitrequest`=0, entries issue back-to-back, one per cycle, using a prefetched table read.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- Timeout counter:
  - counts cycles spent in WAIT_IRQ and saturates;
  - with `TIMEOUT_CYC`=N, the timeout is taken on the N-th WAIT_IRQ cycle.
- `resetn` asserted mid-transfer drops all CRA commands immediately, without waiting for `cra_waitrequest`.

## Structure
- Package `kernel_cra_pkg` holds:
  - the FSM state enum `launcher_state_t`;
  - the entry struct `cra_arg_t` {addr, data, be};
  - the default `STATUS_ADDR`, `START_DATA`, `START_BE`, `CLEAR_DATA` constants.
- Sub-module `kernel_arg_table`: parameterized `ARG_DEPTH`×`cra_arg_t` memory with one write port and one registered read port.

## Test plan
- Load 3 entries {5,64'h1_00000000,F0},{6,64'h1,0F},{D,64'h1000,0F}; start with arg_count=3; `cra_waitrequest`=0 → CRA writes in exactly that order, then (0,64'h1,0F), back-to-back from cycle 2.
- Same launch with `cra_waitrequest` high for 3 cycles on the 2nd write → command held stable for those cycles; no entry is lost or duplicated.
- Raise `kernel_irq` 20 cycles after launch; readback 64'hA → read at address 0, then `status_word`=64'hA, then write (0,64'h0,FF), `done` pulse, `timeout`=0.
- `TIMEOUT_CYC`=50, IRQ never raised → `done` on the 50th WAIT_IRQ cycle +1, `timeout`=1, no read or clear issued; the next `start` clears `timeout`.
- `arg_count`=0; `start` asserted again while busy; `arg_wr_en` pulsed while busy → only the start write is issued, the second start is ignored, and the table is unchanged.
- `resetn` pulled low while `cra_write`=1 under waitrequest → all outputs return to reset values asynchronously; a fresh start afterwards runs normally.
